// File: rtl/drum_mult_pipe.sv
// DRUM-style approximate multiplier: operands truncated to K significant bits, multiplied, re-shifted.
// Latency 3 cycles from the accept cycle to out_valid; throughput one pair per cycle.
// Backpressure: every stage holds while its successor is full and stalled; in_ready = ~s1_vld | s1 advance.
module drum_mult_pipe #(
    parameter int W     = 32,
    parameter int K     = 6,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     out_p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int TW = $clog2(W);

    // Leading-one search: returns {found, position}; the highest set bit wins.
    function automatic logic [TW:0] lead_one(input logic [W-1:0] v);
        logic [TW:0] res;
        res = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) res = {1'b1, TW'(i)};
        end
        return res;
    endfunction

    // Keep the K bits below and including the leading one, force the kept LSB to 1
    // (unbiasing); operands already narrower than K bits pass through exactly.
    // Returns {shift, op}.
    function automatic logic [TW+K-1:0] trunc_op(input logic [W-1:0] v, input logic [TW-1:0] t);
        logic [K-1:0]  op;
        logic [TW-1:0] sh;
        if ({1'b0, t} >= (TW+1)'(K)) begin
            sh = t - TW'(K - 1);
            op = K'(v >> sh) | K'(1);
        end else begin
            sh = '0;
            op = v[K-1:0];
        end
        return {sh, op};
    endfunction

    // Stage enables: a stage loads when it is empty or its contents move on this edge.
    logic w_s1_en, w_s2_en, w_s3_en;
    logic r_s1_vld, r_s2_vld, r_s3_vld;

    assign w_s3_en   = ~r_s3_vld | out_ready;
    assign w_s2_en   = ~r_s2_vld | w_s3_en;
    assign w_s1_en   = ~r_s1_vld | w_s2_en;
    assign in_ready  = w_s1_en;
    assign out_valid = r_s3_vld;

    // ---------------- Stage 1: magnitude, sign, leading-one positions
    logic [W-1:0]  w_mag_a, w_mag_b;
    logic [TW:0]   w_lo_a, w_lo_b;
    logic          w_zero, w_neg;

    // Magnitudes are W-bit unsigned so the most negative value maps to 2^(W-1).
    always_comb begin
        w_mag_a = (in_signed && in_a[W-1]) ? (~in_a + W'(1)) : in_a;
        w_mag_b = (in_signed && in_b[W-1]) ? (~in_b + W'(1)) : in_b;
        w_lo_a  = lead_one(w_mag_a);
        w_lo_b  = lead_one(w_mag_b);
        w_zero  = ~w_lo_a[TW] | ~w_lo_b[TW];
        // A zero product is always reported positive.
        w_neg   = in_signed & (in_a[W-1] ^ in_b[W-1]) & ~w_zero;
    end

    logic [W-1:0]     r_s1_mag_a, r_s1_mag_b;
    logic [TW-1:0]    r_s1_ta, r_s1_tb;
    logic             r_s1_neg, r_s1_zero;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage 1 register: capture an accepted operand pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_mag_a <= '0;
            r_s1_mag_b <= '0;
            r_s1_ta    <= '0;
            r_s1_tb    <= '0;
            r_s1_neg   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_s1_en) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_mag_a <= w_mag_a;
                r_s1_mag_b <= w_mag_b;
                r_s1_ta    <= w_lo_a[TW-1:0];
                r_s1_tb    <= w_lo_b[TW-1:0];
                r_s1_neg   <= w_neg;
                r_s1_zero  <= w_zero;
                r_s1_tag   <= in_tag;
            end
        end
    end

    // ---------------- Stage 2: truncate to K bits, K x K multiply, shift sum
    logic [TW+K-1:0] w_tr_a, w_tr_b;
    logic [2*K-1:0]  w_m;
    logic [TW:0]     w_s;

    // Product of the truncated mantissas; total shift never exceeds 2(W-K).
    always_comb begin
        w_tr_a = trunc_op(r_s1_mag_a, r_s1_ta);
        w_tr_b = trunc_op(r_s1_mag_b, r_s1_tb);
        w_m    = {{K{1'b0}}, w_tr_a[K-1:0]} * {{K{1'b0}}, w_tr_b[K-1:0]};
        w_s    = {1'b0, w_tr_a[TW+K-1:K]} + {1'b0, w_tr_b[TW+K-1:K]};
    end

    logic [2*K-1:0]   r_s2_m;
    logic [TW:0]      r_s2_s;
    logic             r_s2_neg, r_s2_zero;
    logic [TAG_W-1:0] r_s2_tag;

    // Stage 2 register: mantissa product and combined shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_m    <= '0;
            r_s2_s    <= '0;
            r_s2_neg  <= 1'b0;
            r_s2_zero <= 1'b0;
            r_s2_tag  <= '0;
        end else if (w_s2_en) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_m    <= w_m;
                r_s2_s    <= w_s;
                r_s2_neg  <= r_s1_neg;
                r_s2_zero <= r_s1_zero;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    // ---------------- Stage 3: shift back, apply sign
    logic [2*W-1:0] w_r, w_p;

    // m < 2^(2K) and s <= 2W-2K, so the shift cannot overflow 2W bits.
    always_comb begin
        w_r = {{(2*W-2*K){1'b0}}, r_s2_m} << r_s2_s;
        if (r_s2_zero)
            w_p = '0;
        else if (r_s2_neg)
            w_p = ~w_r + (2*W)'(1);
        else
            w_p = w_r;
    end

    // Output register: holds its result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_vld <= 1'b0;
            out_p    <= '0;
            out_tag  <= '0;
        end else if (w_s3_en) begin
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) begin
                out_p   <= w_p;
                out_tag <= r_s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_drum_mult_pipe.sv
// Scoreboard bench for drum_mult_pipe (W=32, K=6): stimulus pushes expected results,
// a negedge monitor pops and compares on every output transfer and checks hold stability.
// Covers reset, exact/truncated paths, sign corners, back-pressure, throughput, async reset.
module tb_drum_mult_pipe;

    localparam int W     = 32;
    localparam int K     = 6;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a, in_b;
    logic              in_signed;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    out_p;
    logic [TAG_W-1:0]  out_tag;

    drum_mult_pipe #(.W(W), .K(K), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] p;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_out   = 0;
    int   n_stall = 0;
    int   cyc     = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Reference: approximate each magnitude independently (clear bits below the
    // K-bit window, set the window's lowest bit), multiply, then apply the sign.
    function automatic longint unsigned approx_mag(input longint unsigned v);
        int t;
        int sh;
        longint unsigned lowmask;
        if (v < (64'd1 << K)) return v;
        t = 63;
        while (!v[t]) t--;
        sh = t - K + 1;
        lowmask = (64'd1 << sh) - 64'd1;
        return (v & ~lowmask) | (64'd1 << sh);
    endfunction

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint unsigned ma, mb, prod;
        ma = (s && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = (s && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        prod = approx_mag(ma) * approx_mag(mb);
        if (s && (a[31] ^ b[31])) return -prod;
        return prod;
    endfunction

    // Consumer: 0 always ready, 1 pattern 1,0,0 repeating, 2 mostly ready at random.
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compare each transferred result; a stalled result must not change.
    initial begin
        bit          stall;
        logic [63:0] held_p;
        logic [3:0]  held_tag;
        exp_t        e;
        stall = 0;
        held_p = '0;
        held_tag = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_p", out_p, held_p);
                    chk("hold_tag", 64'(out_tag), 64'(held_tag));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_out", 64'(q.size()), 64'd1);
                    end else begin
                        e = q.pop_front();
                        chk("out_p", out_p, e.p);
                        chk("out_tag", 64'(out_tag), 64'(e.tag));
                        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
                        n_out++;
                    end
                end
                stall = out_valid && !out_ready;
                held_p = out_p;
                held_tag = out_tag;
            end
        end
    end

    // Present one pair (entered at posedge+1, leaves at posedge+1 after acceptance).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [3:0] tg, input logic [63:0] ep, input bit lat);
        int   n;
        bit   acc;
        exp_t e;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_signed = sg;
        in_tag = tg;
        n = 0;
        acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e.p = ep;
                e.tag = tg;
                e.acc = cyc;
                e.lat = lat;
                q.push_back(e);
            end else begin
                n_stall++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic        vs[6];
        logic [63:0] vp[6];
        logic [31:0] a, b;
        logic        s;
        int          n0;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_signed = 1'b0;
        in_tag = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_p", out_p, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Exact path, latency measured
        send(32'd3, 32'd5, 1'b0, 4'd1, 64'd15, 1'b1);
        drain();

        // Truncation and sign corners, back to back
        va[0] = 32'd1000;       vb[0] = 32'd1;          vs[0] = 1'b0; vp[0] = 64'd1008;
        va[1] = 32'hFFFF_FC18;  vb[1] = 32'd1;          vs[1] = 1'b1; vp[1] = 64'hFFFF_FFFF_FFFF_FC10;
        // 63*63 = 3969, shifted by 26+26 = 52
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'hFFFF_FFFF;  vs[2] = 1'b0; vp[2] = 64'hF810_0000_0000_0000;
        va[3] = 32'h8000_0000;  vb[3] = 32'd1;          vs[3] = 1'b1; vp[3] = 64'hFFFF_FFFF_7C00_0000;
        va[4] = 32'd0;          vb[4] = 32'hFFFF_FFF9;  vs[4] = 1'b1; vp[4] = 64'd0;
        va[5] = 32'hFFFF_FFFD;  vb[5] = 32'd5;          vs[5] = 1'b1; vp[5] = 64'hFFFF_FFFF_FFFF_FFF1;
        for (int i = 0; i < 6; i++) send(va[i], vb[i], vs[i], 4'(i + 2), vp[i], 1'b1);
        drain();

        // Back-pressure: consumer ready 1,0,0,... while 8 tagged pairs stream in
        rdy_mode = 1;
        n0 = n_out;
        for (int i = 0; i < 8; i++) send(32'(i + 2), 32'd3, 1'b0, 4'(i), 64'((i + 2) * 3), 1'b0);
        drain();
        chk("bp_count", 64'(n_out - n0), 64'd8);

        // Full throughput: 20 back-to-back pairs with the consumer always ready
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        n_stall = 0;
        n0 = n_out;
        for (int i = 0; i < 20; i++) begin
            a = 32'(i * i * 12345 + 7) ^ 32'h00F0_0000;
            b = 32'hFFFF_0000 >> i;
            s = 1'(i % 2);
            send(a, b, s, 4'(i), golden(a, b, s), 1'b1);
        end
        chk("tp_stalls", 64'(n_stall), 64'd0);
        drain();
        chk("tp_count", 64'(n_out - n0), 64'd20);

        // Async reset with three pairs in flight
        send(32'd11, 32'd13, 1'b0, 4'd9, 64'd143, 1'b0);
        send(32'd17, 32'd19, 1'b0, 4'd10, 64'd323, 1'b0);
        send(32'd23, 32'd29, 1'b0, 4'd11, 64'd667, 1'b0);
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_p", out_p, 64'd0);
        chk("async_rst_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Random pairs against the reference, consumer randomly stalling
        rdy_mode = 2;
        n0 = n_out;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) a = $urandom_range(0, 100);
            if (i % 5 == 1) b = 32'($urandom_range(0, 40)) - 32'd20;
            if (i == 5) a = 32'h8000_0000;
            if (i == 9) b = 32'd0;
            s = 1'($urandom_range(0, 1));
            send(a, b, s, 4'($urandom_range(0, 15)), golden(a, b, s), 1'b0);
        end
        drain();
        chk("rand_count", 64'(n_out - n0), 64'd30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
